// File: rtl/sev_seg_scan.sv
// Time-multiplexed seven-segment digit scanner: double-buffered value, one-hot
// digit enables with dead time between digits and optional leading-zero blanking.

module sev_seg_scan_lane #(
    parameter bit p_lz_en  = 1'b1,
    parameter bit p_active = 1'b0
) (
    input  logic [3:0] i_nibble,
    input  logic       i_upper_zero,
    input  logic       i_sel,
    output logic       o_zero,
    output logic       o_blank,
    output logic       o_en
);
    // o_zero: this nibble and every more significant one are zero
    assign o_zero  = i_upper_zero && (i_nibble == 4'h0);
    assign o_blank = p_lz_en && o_zero;
    assign o_en    = (i_sel && !o_blank) ? p_active : !p_active;
endmodule

module sev_seg_scan #(
    parameter int p_digits         = 4,
    parameter int p_refresh_cycles = 50000,
    parameter int p_dead_cycles    = 16,
    parameter int p_active         = 0,
    parameter int p_lz_blank       = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [4*p_digits-1:0] i_value,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [3:0]            o_char,
    output logic                  o_blank,
    output logic [p_digits-1:0]   o_digit_en,
    output logic                  o_frame
);
    localparam int CNT_MAX = (p_refresh_cycles > p_dead_cycles) ? p_refresh_cycles : p_dead_cycles;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = (p_digits > 1) ? $clog2(p_digits) : 1;
    localparam logic [CW-1:0] REFRESH_LAST = CW'(p_refresh_cycles - 1);
    localparam logic [CW-1:0] DEAD_LAST    = CW'((p_dead_cycles > 0) ? p_dead_cycles - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST     = IW'(p_digits - 1);
    localparam bit EN_ON  = (p_active != 0);
    localparam bit EN_OFF = !EN_ON;

    typedef enum logic {DEAD, SHOW} state_t;

    state_t                      state, state_nxt;
    logic [CW-1:0]               cnt, cnt_nxt;
    logic [IW-1:0]               idx, idx_nxt;
    logic                        wrap;
    logic [p_digits-1:0][3:0]    disp, disp_nxt, pend;
    logic                        pend_full, pend_full_nxt;
    logic                        accept;
    logic [p_digits:0]           zero_chain;
    logic [p_digits-1:0]         lane_sel, lane_blank, lane_en;
    logic [3:0]                  char_nxt;
    logic                        blank_nxt;

    assign accept = i_valid && o_ready;

    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= DEAD;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        wrap      = 1'b0;
        case (state)
            DEAD: begin
                if (p_dead_cycles == 0 || cnt == DEAD_LAST) begin
                    state_nxt = SHOW;
                    cnt_nxt   = '0;
                end
            end
            SHOW: begin
                if (cnt == REFRESH_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = (p_dead_cycles == 0) ? SHOW : DEAD;
                    if (idx == IDX_LAST) begin
                        idx_nxt = '0;
                        wrap    = 1'b1;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: state_nxt = DEAD;
        endcase
    end

    // Pending value moves to display only on a frame wrap, so no tearing.
    always_comb begin
        disp_nxt      = disp;
        pend_full_nxt = pend_full;
        if (wrap && pend_full) begin
            disp_nxt      = pend;
            pend_full_nxt = 1'b0;
        end
        if (accept)
            pend_full_nxt = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            disp      <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
            o_ready   <= 1'b1;
        end else begin
            disp      <= disp_nxt;
            pend_full <= pend_full_nxt;
            o_ready   <= !pend_full_nxt;
            if (accept)
                pend <= i_value;
        end
    end

    // Lanes see next-cycle display/index so registered outputs line up with state.
    assign zero_chain[p_digits] = 1'b1;

    genvar k;
    generate
        for (k = 0; k < p_digits; k++) begin : g_lane
            assign lane_sel[k] = (state_nxt == SHOW) && (idx_nxt == IW'(k));
            sev_seg_scan_lane #(
                .p_lz_en  ((p_lz_blank != 0) && (k > 0)),
                .p_active (EN_ON)
            ) u_lane (
                .i_nibble     (disp_nxt[k]),
                .i_upper_zero (zero_chain[k+1]),
                .i_sel        (lane_sel[k]),
                .o_zero       (zero_chain[k]),
                .o_blank      (lane_blank[k]),
                .o_en         (lane_en[k])
            );
        end
    endgenerate

    // output logic
    always_comb begin
        char_nxt  = o_char;
        blank_nxt = 1'b0;
        if (state_nxt == SHOW) begin
            char_nxt  = disp_nxt[idx_nxt];
            blank_nxt = lane_blank[idx_nxt];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_digit_en <= {p_digits{EN_OFF}};
            o_char     <= 4'h0;
            o_blank    <= 1'b0;
            o_frame    <= 1'b0;
        end else begin
            o_digit_en <= lane_en;
            o_char     <= char_nxt;
            o_blank    <= blank_nxt;
            o_frame    <= wrap;
        end
    end

endmodule

// File: tb/tb_sev_seg_scan.sv
// Directed bench for sev_seg_scan: table-driven frame scans plus hand-written
// back-pressure, mid-scan reset and zero-dead-time sequences.

module tb_sev_seg_scan;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value_a = '0, value_b = '0;
    logic        valid_a = 1'b0, valid_b = 1'b0;
    logic        ready_a, ready_b;
    logic [3:0]  char_a, char_b;
    logic        blank_a, blank_b;
    logic [3:0]  en_a, en_b;
    logic        frame_a, frame_b;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    sev_seg_scan #(.p_digits(4), .p_refresh_cycles(4), .p_dead_cycles(2),
                   .p_active(0), .p_lz_blank(1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_value(value_a), .i_valid(valid_a),
        .o_ready(ready_a), .o_char(char_a), .o_blank(blank_a),
        .o_digit_en(en_a), .o_frame(frame_a));

    sev_seg_scan #(.p_digits(4), .p_refresh_cycles(4), .p_dead_cycles(0),
                   .p_active(0), .p_lz_blank(1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_value(value_b), .i_valid(valid_b),
        .o_ready(ready_b), .o_char(char_b), .o_blank(blank_b),
        .o_digit_en(en_b), .o_frame(frame_b));

    typedef struct {
        logic [15:0] value;
        logic [15:0] en;   // expected enable per digit slot, slot d in [4d+:4]
        logic [15:0] ch;
        logic [3:0]  bl;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [15:0] v);
        int n;
        value_a = v;
        valid_a = 1'b1;
        n = 0;
        while (!ready_a && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) chk("load_timeout", 0, 1);
        step();
        valid_a = 1'b0;
        chk("ready_low_after_accept", ready_a, 0);
    endtask

    task automatic wait_frame_a();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_a && n < 200);
        if (n >= 200) chk("frame_timeout", 0, 1);
    endtask

    // Starts on the o_frame cycle, ends on the next o_frame cycle.
    task automatic scan_check(input vec_t v);
        int slot, ph;
        for (int c = 0; c < 24; c++) begin
            slot = c / 6;
            ph = c % 6;
            if (ph < 2)
                chk($sformatf("dead c%0d", c), {frame_a, en_a}, {(c == 0), 4'hF});
            else
                chk($sformatf("show %h c%0d", v.value, c),
                    {frame_a, en_a, char_a, blank_a},
                    {1'b0, v.en[slot*4 +: 4], v.ch[slot*4 +: 4], v.bl[slot]});
            step();
        end
        chk("frame_period", frame_a, 1);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{16'h1234, 16'h7BDE, 16'h1234, 4'b0000};
        vecs[1] = '{16'h000A, 16'hFFFE, 16'h000A, 4'b1110};
        vecs[2] = '{16'h0000, 16'hFFFE, 16'h0000, 4'b1110};
        vecs[3] = '{16'h0100, 16'hFBDE, 16'h0100, 4'b1000};
        vecs[4] = '{16'h00AB, 16'hFFDE, 16'h00AB, 4'b1100};
        vecs[5] = '{16'hFFFF, 16'h7BDE, 16'hFFFF, 4'b0000};

        // reset state
        repeat (3) step();
        chk("rst_ready", ready_a, 1);
        chk("rst_en", en_a, 4'hF);
        chk("rst_char", char_a, 0);
        chk("rst_frame", frame_a, 0);
        chk("rst_blank", blank_a, 0);
        rst_n = 1'b1;
        chk("post_rst_dead0", en_a, 4'hF);
        step();
        chk("post_rst_dead1", en_a, 4'hF);
        step();
        chk("post_rst_show0", {en_a, char_a, blank_a}, {4'b1110, 4'h0, 1'b0});

        // table-driven load and scan
        for (int i = 0; i < 4; i++) begin
            load_a(vecs[i].value);
            wait_frame_a();
            scan_check(vecs[i]);
        end

        // back-pressure: 00AB then FFFF held valid
        load_a(vecs[4].value);
        value_a = 16'hFFFF;
        valid_a = 1'b1;
        step();
        chk("bp_ready_held_low", ready_a, 0);
        wait_frame_a();
        chk("bp_ready_back", ready_a, 1);
        scan_check(vecs[4]);
        valid_a = 1'b0;
        scan_check(vecs[5]);

        // reset mid-SHOW of digit 2 with 1234 shown and 5678 pending
        load_a(16'h1234);
        wait_frame_a();
        value_a = 16'h5678;
        valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        repeat (14) step();
        chk("mid_show_d2", {en_a, char_a}, {4'b1011, 4'h2});
        chk("mid_pending_full", ready_a, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_en", en_a, 4'hF);
        chk("async_rst_ready", ready_a, 1);
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("after_rst_d0", {en_a, char_a, blank_a}, {4'b1110, 4'h0, 1'b0});
        repeat (6) step();
        chk("after_rst_d1_blank", {en_a, char_a, blank_a}, {4'b1111, 4'h0, 1'b1});
        chk("after_rst_ready", ready_a, 1);

        // zero dead time
        begin
            int n;
            logic [3:0] exp_en [4];
            exp_en[0] = 4'b1110; exp_en[1] = 4'b1101;
            exp_en[2] = 4'b1011; exp_en[3] = 4'b0111;
            value_b = 16'h1234;
            valid_b = 1'b1;
            step();
            valid_b = 1'b0;
            n = 0;
            do begin
                step();
                n++;
            end while (!frame_b && n < 200);
            if (n >= 200) chk("b_frame_timeout", 0, 1);
            for (int c = 0; c < 16; c++) begin
                chk($sformatf("nodead c%0d", c), {frame_b, en_b, char_b},
                    {(c == 0), exp_en[c/4], 4'(4 - c/4)});
                step();
            end
            chk("nodead_frame_period", {frame_b, en_b}, {1'b1, 4'b1110});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end
endmodule

// File: doc/sev_seg_scan.md
Name: sev_seg_scan

Overview:
Time-multiplexed scanner for a common-anode/common-cathode multi-digit seven-segment display. Accepts a packed hex value over a valid/ready handshake, double-buffers it so updates land only on frame boundaries, and cycles through the digits one at a time. For each digit it drives a one-hot digit enable plus the 4-bit nibble (o_char) that feeds the downstream sev_seg decoder. A dead-time interval between digits suppresses ghosting. Optional leading-zero blanking is included.

Parameters:
p_digits, 4, number of digits scanned; value width is 4*p_digits.
p_refresh_cycles, 50000, clock cycles each digit stays lit; must be >= 1.
p_dead_cycles, 16, cycles with all digits off between digits; 0 disables dead time.
p_active, 0, digit-enable polarity; 1 = active-high, 0 = active-low.
p_lz_blank, 1, 1 = suppress leading zeros.

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_value  input  4*p_digits  packed hex value; nibble [3:0] is digit 0, the least significant/rightmost digit
i_valid  input  1  i_value is valid
o_ready  output  1  pending buffer is empty; transfer occurs when i_valid && o_ready at a rising edge
o_char  output  4  nibble of the currently selected digit, to sev_seg i_char
o_blank  output  1  current digit is blanked by leading-zero suppression
o_digit_en  output  p_digits  one-hot digit enable, polarity per p_active
o_frame  output  1  one-cycle pulse at the end of each full scan

Behaviour:
- Clock/reset: single clock i_clk; reset is asynchronous, active-low. All outputs are registered.
- Reset values:
  - display and pending registers = 0; pending empty; o_ready = 1.
  - digit index = 0; state = DEAD; cycle counter = 0.
  - o_digit_en all inactive (all 0 if p_active=1, all 1 if p_active=0).
  - o_char = 0, o_blank = 0, o_frame = 0.
- Handshake:
  - On i_valid && o_ready, i_value is latched into pending, pending is marked full, and o_ready goes 0 the next cycle.
  - o_ready stays 0 until the pending value is transferred into display.
- FSM states: DEAD, SHOW.
  - DEAD: all enables inactive. Lasts p_dead_cycles cycles, then enters SHOW. If p_dead_cycles = 0, DEAD is skipped: SHOW goes directly to SHOW of the next digit.
  - SHOW: the enable for the current index is active (unless blanked), and o_char = display nibble[index]. Lasts p_refresh_cycles cycles, then the index advances and the FSM enters DEAD.
- Index wrap: after index p_digits-1 the index returns to 0. On that wrap transition:
  - o_frame pulses high for one cycle.
  - If pending is full: display <= pending, pending is cleared, and o_ready = 1 on the following cycle.
  - No handshake accept can occur in the transfer cycle because o_ready = 0 there. There is no simultaneous load/transfer conflict.
- Latency: an accepted value appears starting at digit 0 of the frame following the next wrap. It is never shown mid-frame, so there is no tearing.
- Leading-zero blank (p_lz_blank=1): digit k > 0 is blanked when nibbles k..p_digits-1 of display are all zero.
  - A blanked digit gets o_blank = 1 and its enable stays inactive during its SHOW slot.
  - o_char still carries the nibble for a blanked digit.
  - Digit 0 is never blanked, so value 0 shows "0".
  - With p_lz_blank=0, o_blank is always 0.
- Timing: o_blank and o_char are updated in the same cycle as o_digit_en. o_char holds its last value during DEAD.
- Reset mid-operation: enables go inactive immediately (asynchronously), and the pending and display contents are lost.

Test Plan:
- Reset: assert i_rst_n=0 for 3 cycles -> o_ready=1, o_digit_en=4'b1111 (p_active=0), o_char=0, o_frame=0. Release reset -> 2 DEAD cycles, then digit 0 SHOW.
- Load and scan (p_digits=4, p_refresh_cycles=4, p_dead_cycles=2): accept 16'h1234 -> after the next o_frame, the sequence is o_char 4/3/2/1 with o_digit_en 1110/1101/1011/0111. Each digit is lit 4 cycles, separated by 2 cycles of 1111. o_frame pulses once per 24 cycles.
- Back-pressure: accept 16'h00AB, then hold i_valid with 16'hFFFF -> o_ready=0 until the wrap. 0x00AB is displayed; 16'hFFFF is accepted the cycle after o_ready returns to 1 and is displayed one frame later.
- Leading zeros: load 16'h000A -> digit 0 shows A lit; digits 1-3 have o_blank=1 and enables inactive. Load 16'h0000 -> digit 0 shows 0 lit. Load 16'h0100 -> digits 0 and 1 show 0 lit, digit 2 shows 1 lit, digit 3 blanked.
- Reset mid-SHOW on digit 2 with 16'h1234 displayed and 16'h5678 pending -> o_digit_en=1111 with no clock edge required. After release, the display is 0 ("0" on digit 0 only) and o_ready=1.
- p_dead_cycles=0: load 16'h1234 -> enables step 1110->1101->1011->0111 back to back with no all-off cycles.
